uart_echo_buffer: RTL

- Byte FIFO and transmit sequencer between the 8N1 UART receiver and the 8N1 UART transmitter on the echo path.
- Captures each byte announced by the receiver's done strobe and buffers it.
- Hands buffered bytes one at a time to the transmitter with a level handshake, so slow-baud transmit never loses fast bursts.
- Optional line mode holds output until a full CR-terminated line is buffered.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_byte_fifo.sv | 57 +++++
 rtl/uart_echo_buffer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and the sequencer state encoding for the UART echo path.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CR_CODE = 8'h0D;
  localparam logic [BYTE_W-1:0] LF_CODE = 8'h0A;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StSend = 2'd2,
    StWait = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO; callers must not push when full without a pop, nor pop when empty.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [BYTE_W-1:0] wdata_i,
  output logic [BYTE_W-1:0] rdata_o,
  output logic [AW:0]       level_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q, level_d;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case ({push_i, pop_i})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == FullLvl);
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers received bytes and hands them one at a time to the UART transmitter
// over a send/done level handshake, with optional hold-until-CR line mode.
module uart_echo_buffer
  import uart_pkg::*;
#(
  parameter int unsigned       DEPTH       = 16,
  parameter int unsigned       AW          = 4,
  parameter int unsigned       LINE_MODE   = 0,
  parameter logic [BYTE_W-1:0] CR_CODE     = uart_pkg::CR_CODE,
  parameter int unsigned       TIMEOUT_CYC = 120000
) (
  input  logic              hwclk,
  input  logic              rstn,
  input  logic [BYTE_W-1:0] rx_byte,
  input  logic              rx_done,
  output logic [BYTE_W-1:0] tx_byte,
  output logic              tx_send,
  input  logic              tx_done,
  output logic [AW:0]       level,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              tx_timeout,
  input  logic              clear_flags
);

  localparam int unsigned   TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYC - 1);

  uart_state_e       state_q, state_d;
  logic              rx_done_q;
  logic              push, fifo_push, pop, ovf_hit, tmo_hit, start;
  logic              push_cr, pop_cr;
  logic [BYTE_W-1:0] head;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [AW:0]       lines_pending_q, lines_pending_d;
  logic              overflow_q, tx_timeout_q;

  // A full FIFO still accepts a push when the same cycle pops.
  assign push      = rx_done & ~rx_done_q;
  assign fifo_push = push & (~full | pop);
  assign ovf_hit   = push & full & ~pop;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk_i   (hwclk),
    .rst_ni  (rstn),
    .push_i  (fifo_push),
    .pop_i   (pop),
    .wdata_i (rx_byte),
    .rdata_o (head),
    .level_o (level),
    .full_o  (full),
    .empty_o (empty)
  );

  assign push_cr = fifo_push & (rx_byte == CR_CODE);
  assign pop_cr  = pop & (head == CR_CODE);

  always_comb begin
    lines_pending_d = lines_pending_q;
    if (push_cr && !pop_cr) begin
      lines_pending_d = lines_pending_q + (AW + 1)'(1);
    end else if (pop_cr && !push_cr) begin
      lines_pending_d = lines_pending_q - (AW + 1)'(1);
    end
  end

  // Full overrides line mode so an over-long line cannot deadlock the buffer.
  assign start = ~empty & ((LINE_MODE == 0) | (lines_pending_q != '0) | full);

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    tmo_cnt_d = tmo_cnt_q;
    pop       = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        pop       = 1'b1;
        tx_byte_d = head;
        tmo_cnt_d = '0;
        state_d   = StSend;
      end
      StSend: begin
        if (!tx_done) begin
          tmo_cnt_d = '0;
          state_d   = StWait;
        end else if (tmo_cnt_q == TmoLast) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      StWait: begin
        if (tx_done) begin
          state_d = StIdle;
        end else if (tmo_cnt_q == TmoLast) begin
          tmo_hit = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hwclk) begin
    if (!rstn) begin
      state_q         <= StIdle;
      rx_done_q       <= 1'b1;
      tx_byte_q       <= '0;
      tmo_cnt_q       <= '0;
      lines_pending_q <= '0;
      overflow_q      <= 1'b0;
      tx_timeout_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      rx_done_q       <= rx_done;
      tx_byte_q       <= tx_byte_d;
      tmo_cnt_q       <= tmo_cnt_d;
      lines_pending_q <= lines_pending_d;
      overflow_q      <= ovf_hit | (overflow_q & ~clear_flags);
      tx_timeout_q    <= tmo_hit | (tx_timeout_q & ~clear_flags);
    end
  end

  assign tx_byte    = tx_byte_q;
  assign tx_send    = (state_q == StSend);
  assign overflow   = overflow_q;
  assign tx_timeout = tx_timeout_q;

endmodule
